// File: rtl/rsa_decryptor_if.sv
// Command/result bundle for the RSA decryptor: operand plus command type in, status and result out.
interface rsa_decryptor_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] data;
  logic [2:0]       input_data_type;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] output_data;

  modport master (
    output data,
    output input_data_type,
    input  busy,
    input  done,
    input  output_data
  );

  modport slave (
    input  data,
    input  input_data_type,
    output busy,
    output done,
    output output_data
  );
endinterface

// File: rtl/rsa_decryptor.sv
// RSA decryptor: m = c^d mod n by right-to-left square-and-multiply over a
// bit-serial interleaved modular multiplier that consumes one multiplier bit per cycle.
module rsa_decryptor #(
  parameter int WIDTH     = 16,
  parameter int D_DEFAULT = 3,
  parameter int N_DEFAULT = 33
) (
  input  logic          clk,
  input  logic          reset,
  rsa_decryptor_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_RED,
    S_MUL,
    S_SQR,
    S_FIN
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] d_reg, n_reg, c_reg, e_reg, r_reg, b_reg;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;
  logic             done_reg;
  logic [WIDTH-1:0] out_reg;

  logic [WIDTH-1:0] mul_a, mul_b, e_view, dbl_red, acc_next;
  logic [WIDTH:0]   n_ext, dbl, addend, sum;
  logic             phase_done;

  // Operand routing: RED reduces c via 1*c, MUL folds B into R, SQR squares B.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state)
      S_RED: begin
        mul_a = WIDTH'(1);
        mul_b = c_reg;
      end
      S_MUL: begin
        mul_a = r_reg;
        mul_b = b_reg;
      end
      S_SQR: begin
        mul_a = b_reg;
        mul_b = b_reg;
      end
      default: ;
    endcase
  end

  // One interleaved step; acc < n holds, so each reduction needs only one subtract.
  always_comb begin
    n_ext    = {1'b0, n_reg};
    dbl      = {acc, 1'b0};
    dbl_red  = (dbl >= n_ext) ? WIDTH'(dbl - n_ext) : WIDTH'(dbl);
    addend   = mul_b[cnt] ? {1'b0, mul_a} : '0;
    sum      = {1'b0, dbl_red} + addend;
    acc_next = (sum >= n_ext) ? WIDTH'(sum - n_ext) : WIDTH'(sum);
  end

  assign phase_done = (cnt == '0);
  // After a square the exponent shifts, so decide the next phase on the shifted value.
  assign e_view     = (state == S_SQR) ? (e_reg >> 1) : e_reg;

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (bus.input_data_type == 3'd1) state_next = S_SETUP;
      S_SETUP: state_next = (n_reg < WIDTH'(2)) ? S_FIN : S_RED;
      S_RED, S_SQR: begin
        if (phase_done) begin
          if (e_view[0])                 state_next = S_MUL;
          else if (|e_view[WIDTH-1:1])   state_next = S_SQR;
          else                           state_next = S_FIN;
        end
      end
      S_MUL: begin
        if (phase_done) state_next = (|e_reg[WIDTH-1:1]) ? S_SQR : S_FIN;
      end
      S_FIN:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      d_reg    <= WIDTH'(D_DEFAULT);
      n_reg    <= WIDTH'(N_DEFAULT);
      c_reg    <= '0;
      e_reg    <= '0;
      r_reg    <= '0;
      b_reg    <= '0;
      acc      <= '0;
      cnt      <= CW'(WIDTH - 1);
      done_reg <= 1'b0;
      out_reg  <= '0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: begin
          case (bus.input_data_type)
            3'd1: begin
              c_reg    <= bus.data;
              e_reg    <= d_reg;
              done_reg <= 1'b0;
            end
            3'd2:    d_reg <= bus.data;
            3'd3:    n_reg <= bus.data;
            default: ;
          endcase
        end
        S_SETUP: begin
          r_reg <= (n_reg < WIDTH'(2)) ? '0 : WIDTH'(1);
          acc   <= '0;
          cnt   <= CW'(WIDTH - 1);
        end
        S_RED, S_MUL, S_SQR: begin
          if (phase_done) begin
            acc <= '0;
            cnt <= CW'(WIDTH - 1);
            if (state == S_MUL) r_reg <= acc_next;
            else                b_reg <= acc_next;
            if (state == S_SQR) e_reg <= e_reg >> 1;
          end else begin
            acc <= acc_next;
            cnt <= cnt - CW'(1);
          end
        end
        S_FIN: begin
          out_reg  <= r_reg;
          done_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = (state != S_IDLE);
  assign bus.done        = done_reg;
  assign bus.output_data = out_reg;

endmodule
